// File: rtl/snake_grid_engine.sv
`default_nettype none
// ============================================================================
// Module   : snake_grid_engine
// Purpose  : Snake body engine: ring-buffer segments plus a grid occupancy
//            bitmap, per-tick head move, wall/self collision and cell query.
// Revision : 1.0 - initial release
// ============================================================================
module snake_grid_engine #(
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 48,
  parameter int MAX_LEN = 16,
  parameter int START_X = 16,
  parameter int START_Y = 16,
  parameter int WRAP    = 0,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [3:0]    dir,
  input  logic          grow,
  input  logic [XW-1:0] q_x,
  input  logic [YW-1:0] q_y,
  output logic          q_occ,
  output logic          q_head,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          busy,
  output logic          moved,
  output logic          game_over,
  output logic          win
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int GW    = $clog2(NCELL);
  localparam int PW    = $clog2(MAX_LEN);

  localparam logic [XW:0]      c_GRID_W   = (XW+1)'(GRID_W);
  localparam logic [YW:0]      c_GRID_H   = (YW+1)'(GRID_H);
  localparam logic [XW-1:0]    c_X_MAX    = XW'(GRID_W - 1);
  localparam logic [YW-1:0]    c_Y_MAX    = YW'(GRID_H - 1);
  localparam logic [XW-1:0]    c_START_X  = XW'(START_X);
  localparam logic [YW-1:0]    c_START_Y  = YW'(START_Y);
  localparam logic [LW-1:0]    c_MAX_LEN  = LW'(MAX_LEN);
  localparam logic [PW-1:0]    c_PTR_MAX  = PW'(MAX_LEN - 1);
  localparam logic [NCELL-1:0] c_GRID_INIT =
    {{(NCELL-1){1'b0}}, 1'b1} << (START_Y * GRID_W + START_X);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t           r_state;
  logic [NCELL-1:0] r_grid;
  logic [XW-1:0]    r_segX [MAX_LEN];
  logic [YW-1:0]    r_segY [MAX_LEN];
  logic [PW-1:0]    r_headPtr;
  logic [PW-1:0]    r_tailPtr;
  logic [3:0]       r_heading;
  logic             r_growPend;
  logic [XW-1:0]    r_headX;
  logic [YW-1:0]    r_headY;
  logic [XW-1:0]    r_nextX;
  logic [YW-1:0]    r_nextY;
  logic [LW-1:0]    r_length;
  logic             r_qOcc;
  logic             r_qHead;
  logic             r_moved;
  logic             r_gameOver;
  logic             r_win;

  logic [3:0]       w_opposite;
  logic             w_dirOk;
  logic [PW-1:0]    w_headPtrNext;
  logic [PW-1:0]    w_tailPtrNext;
  logic [XW-1:0]    w_stepX;
  logic [YW-1:0]    w_stepY;
  logic             w_wall;
  logic [XW-1:0]    w_tailX;
  logic [YW-1:0]    w_tailY;
  logic [GW-1:0]    w_nextIdx;
  logic [GW-1:0]    w_tailIdx;
  logic [GW-1:0]    w_qIdx;
  logic             w_nextIsTail;
  logic             w_hit;
  logic             w_qIn;

  function automatic logic [GW-1:0] cellIdx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return GW'(y) * GW'(GRID_W) + GW'(x);
  endfunction

  // Up/down and left/right are each other's opposites: swap the bit pairs.
  assign w_opposite    = {r_heading[1], r_heading[0], r_heading[3], r_heading[2]};
  assign w_dirOk       = $onehot(dir) && (dir != w_opposite);
  assign w_headPtrNext = (r_headPtr == c_PTR_MAX) ? '0 : r_headPtr + 1'b1;
  assign w_tailPtrNext = (r_tailPtr == c_PTR_MAX) ? '0 : r_tailPtr + 1'b1;

  always_comb begin
    w_stepX = r_headX;
    w_stepY = r_headY;
    w_wall  = 1'b0;
    case (r_heading)
      4'b0001: begin
        if (r_headY == '0) begin
          if (WRAP != 0) w_stepY = c_Y_MAX;
          else           w_wall  = 1'b1;
        end else begin
          w_stepY = r_headY - 1'b1;
        end
      end
      4'b0010: begin
        if (r_headX == '0) begin
          if (WRAP != 0) w_stepX = c_X_MAX;
          else           w_wall  = 1'b1;
        end else begin
          w_stepX = r_headX - 1'b1;
        end
      end
      4'b0100: begin
        if (r_headY == c_Y_MAX) begin
          if (WRAP != 0) w_stepY = '0;
          else           w_wall  = 1'b1;
        end else begin
          w_stepY = r_headY + 1'b1;
        end
      end
      4'b1000: begin
        if (r_headX == c_X_MAX) begin
          if (WRAP != 0) w_stepX = '0;
          else           w_wall  = 1'b1;
        end else begin
          w_stepX = r_headX + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_tailX      = r_segX[r_tailPtr];
  assign w_tailY      = r_segY[r_tailPtr];
  assign w_nextIdx    = cellIdx(r_nextX, r_nextY);
  assign w_tailIdx    = cellIdx(w_tailX, w_tailY);
  assign w_nextIsTail = (r_nextX == w_tailX) && (r_nextY == w_tailY);
  // The tail cell is free to enter unless a pending grow keeps the tail in place.
  assign w_hit        = r_grid[w_nextIdx] && !(w_nextIsTail && !r_growPend);
  assign w_qIn        = ({1'b0, q_x} < c_GRID_W) && ({1'b0, q_y} < c_GRID_H);
  assign w_qIdx       = cellIdx(q_x, q_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grid     <= c_GRID_INIT;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_segX[i] <= c_START_X;
        r_segY[i] <= c_START_Y;
      end
      r_headPtr  <= '0;
      r_tailPtr  <= '0;
      r_heading  <= 4'b0000;
      r_growPend <= 1'b0;
      r_headX    <= c_START_X;
      r_headY    <= c_START_Y;
      r_nextX    <= c_START_X;
      r_nextY    <= c_START_Y;
      r_length   <= LW'(1);
      r_qOcc     <= 1'b0;
      r_qHead    <= 1'b0;
      r_moved    <= 1'b0;
      r_gameOver <= 1'b0;
      r_win      <= 1'b0;
    end else begin
      r_moved <= 1'b0;
      r_qOcc  <= w_qIn && r_grid[w_qIdx];
      r_qHead <= w_qIn && (q_x == r_headX) && (q_y == r_headY);
      if (w_dirOk) r_heading <= dir;

      case (r_state)
        S_IDLE: begin
          if (tick && (r_heading != 4'b0000) && !r_gameOver && !r_win)
            r_state <= S_STEP;
        end
        S_STEP: begin
          if (w_wall) begin
            r_gameOver <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_nextX <= w_stepX;
            r_nextY <= w_stepY;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_hit) begin
            r_gameOver <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_headPtr            <= w_headPtrNext;
          r_segX[w_headPtrNext] <= r_nextX;
          r_segY[w_headPtrNext] <= r_nextY;
          r_headX              <= r_nextX;
          r_headY              <= r_nextY;
          // Tail clear is issued before the head set so a shared cell stays set.
          if (!r_growPend) begin
            r_grid[w_tailIdx] <= 1'b0;
            r_tailPtr         <= w_tailPtrNext;
          end else begin
            r_length <= r_length + 1'b1;
            if ((r_length + 1'b1) == c_MAX_LEN) r_win <= 1'b1;
          end
          r_grid[w_nextIdx] <= 1'b1;
          r_growPend        <= 1'b0;
          r_moved           <= 1'b1;
          r_state           <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (grow) r_growPend <= 1'b1;
    end
  end

  assign q_occ     = r_qOcc;
  assign q_head    = r_qHead;
  assign head_x    = r_headX;
  assign head_y    = r_headY;
  assign length    = r_length;
  assign busy      = (r_state != S_IDLE);
  assign moved     = r_moved;
  assign game_over = r_gameOver;
  assign win       = r_win;

endmodule
`default_nettype wire

// File: tb/tb_snake_grid_engine.sv
`default_nettype none
// Three engines (wall, wrap, short max length) share one stimulus stream;
// a list-of-cells snake model predicts every move and collision.
module tb_snake_grid_engine;

  localparam int NDUT = 3;
  localparam int GW   = 64;
  localparam int GH   = 48;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       grow = 1'b0;
  logic [3:0] dir = 4'b0000;
  logic [5:0] qx = '0;
  logic [5:0] qy = '0;

  logic [5:0] hx [NDUT];
  logic [5:0] hy [NDUT];
  logic       qocc [NDUT];
  logic       qhead [NDUT];
  logic       busy [NDUT];
  logic       moved [NDUT];
  logic       go [NDUT];
  logic       win [NDUT];
  logic [4:0] len0;
  logic [4:0] len1;
  logic [2:0] len2;

  always #5 clk = ~clk;

  snake_grid_engine #(.GRID_W(64), .GRID_H(48), .MAX_LEN(16), .START_X(16), .START_Y(16), .WRAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .dir(dir), .grow(grow), .q_x(qx), .q_y(qy),
    .q_occ(qocc[0]), .q_head(qhead[0]), .head_x(hx[0]), .head_y(hy[0]), .length(len0),
    .busy(busy[0]), .moved(moved[0]), .game_over(go[0]), .win(win[0]));

  snake_grid_engine #(.GRID_W(64), .GRID_H(48), .MAX_LEN(16), .START_X(16), .START_Y(16), .WRAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .dir(dir), .grow(grow), .q_x(qx), .q_y(qy),
    .q_occ(qocc[1]), .q_head(qhead[1]), .head_x(hx[1]), .head_y(hy[1]), .length(len1),
    .busy(busy[1]), .moved(moved[1]), .game_over(go[1]), .win(win[1]));

  snake_grid_engine #(.GRID_W(64), .GRID_H(48), .MAX_LEN(4), .START_X(16), .START_Y(16), .WRAP(0)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .dir(dir), .grow(grow), .q_x(qx), .q_y(qy),
    .q_occ(qocc[2]), .q_head(qhead[2]), .head_x(hx[2]), .head_y(hy[2]), .length(len2),
    .busy(busy[2]), .moved(moved[2]), .game_over(go[2]), .win(win[2]));

  typedef struct packed {
    int k;
    bit isGo;
    int x;
    int y;
    int len;
    bit win;
    int cycle;
  } exp_t;

  exp_t       sbQ [$];
  int         nTests = 0;
  int         nFail = 0;
  int         cyc = 0;
  bit         goPrev [NDUT];

  int         mX [NDUT];
  int         mY [NDUT];
  int         mLen [NDUT];
  bit         mGo [NDUT];
  bit         mWin [NDUT];
  bit         mGp [NDUT];
  logic [3:0] mHd [NDUT];
  int         bx [NDUT][20];
  int         by [NDUT][20];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit wrapOf(input int k);
    return k == 1;
  endfunction

  function automatic int maxLenOf(input int k);
    return (k == 2) ? 4 : 16;
  endfunction

  function automatic int getLen(input int k);
    case (k)
      0:       return int'(len0);
      1:       return int'(len1);
      default: return int'(len2);
    endcase
  endfunction

  function automatic void check(input string name, input int act, input int req);
    nTests++;
    if (act != req) begin
      nFail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  function automatic bit inBody(input int k, input int x, input int y);
    for (int i = 0; i < mLen[k]; i++)
      if (bx[k][i] == x && by[k][i] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] opp(input logic [3:0] h);
    case (h)
      4'b0001: return 4'b0100;
      4'b0100: return 4'b0001;
      4'b0010: return 4'b1000;
      4'b1000: return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < NDUT; k++) begin
      mX[k] = 16; mY[k] = 16; mLen[k] = 1;
      bx[k][0] = 16; by[k][0] = 16;
      mGo[k] = 1'b0; mWin[k] = 1'b0; mGp[k] = 1'b0; mHd[k] = 4'b0000;
    end
  endfunction

  // Returns 1 when the engine is expected to leave IDLE for this tick.
  function automatic bit predict(input int k, input int tS);
    int nx, ny;
    bit hit;
    exp_t e;
    if (mHd[k] == 4'b0000 || mGo[k] || mWin[k]) return 1'b0;
    nx = mX[k]; ny = mY[k]; hit = 1'b0;
    case (mHd[k])
      4'b0001: ny = ny - 1;
      4'b0010: nx = nx - 1;
      4'b0100: ny = ny + 1;
      default: nx = nx + 1;
    endcase
    e.k = k; e.cycle = tS + 3; e.isGo = 1'b0;
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      if (wrapOf(k)) begin
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
      end else begin
        hit = 1'b1;
      end
    end
    if (!hit)
      for (int i = 0; i < mLen[k]; i++)
        if (bx[k][i] == nx && by[k][i] == ny && !(i == mLen[k] - 1 && !mGp[k])) hit = 1'b1;
    if (hit) begin
      mGo[k] = 1'b1;
      e.isGo = 1'b1; e.x = mX[k]; e.y = mY[k]; e.len = mLen[k]; e.win = 1'b0;
      sbQ.push_back(e);
      return 1'b1;
    end
    if (mGp[k]) mLen[k] = mLen[k] + 1;
    for (int i = mLen[k] - 1; i > 0; i--) begin
      bx[k][i] = bx[k][i-1];
      by[k][i] = by[k][i-1];
    end
    bx[k][0] = nx; by[k][0] = ny;
    mX[k] = nx; mY[k] = ny; mGp[k] = 1'b0;
    if (mLen[k] == maxLenOf(k)) mWin[k] = 1'b1;
    e.x = nx; e.y = ny; e.len = mLen[k]; e.win = mWin[k];
    sbQ.push_back(e);
    return 1'b1;
  endfunction

  task automatic scoreMatch(input int k, input bit isGo);
    int idx;
    exp_t e;
    idx = -1;
    for (int i = 0; i < sbQ.size(); i++)
      if (idx < 0 && sbQ[i].k == k) idx = i;
    if (idx < 0) begin
      nTests++;
      nFail++;
      $display("FAIL dut%0d unexpected_event: got %s, required none", k, isGo ? "game_over" : "moved");
      return;
    end
    e = sbQ[idx];
    sbQ.delete(idx);
    check($sformatf("dut%0d event_is_game_over", k), int'(isGo), int'(e.isGo));
    check($sformatf("dut%0d head_x", k), int'(hx[k]), e.x);
    check($sformatf("dut%0d head_y", k), int'(hy[k]), e.y);
    check($sformatf("dut%0d length", k), getLen(k), e.len);
    check($sformatf("dut%0d win", k), int'(win[k]), int'(e.win));
    if (!isGo) begin
      check($sformatf("dut%0d moved_cycle", k), cyc, e.cycle);
      check($sformatf("dut%0d game_over_at_move", k), int'(go[k]), 0);
    end
  endtask

  // Monitor: every moved pulse or game_over rise consumes one expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (!rst) begin
        if (moved[k]) scoreMatch(k, 1'b0);
        if (go[k] && !goPrev[k]) scoreMatch(k, 1'b1);
      end
      goPrev[k] = go[k];
    end
  end

  task automatic applyReset(input bit midMove);
    if (midMove) begin
      @(negedge clk); dir = 4'b1000;
      @(negedge clk); dir = 4'b0000; tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbQ.delete();
    modelReset();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d rst head_x", k), int'(hx[k]), 16);
      check($sformatf("dut%0d rst head_y", k), int'(hy[k]), 16);
      check($sformatf("dut%0d rst length", k), getLen(k), 1);
      check($sformatf("dut%0d rst q_occ", k), int'(qocc[k]), 0);
      check($sformatf("dut%0d rst q_head", k), int'(qhead[k]), 0);
      check($sformatf("dut%0d rst busy", k), int'(busy[k]), 0);
      check($sformatf("dut%0d rst moved", k), int'(moved[k]), 0);
      check($sformatf("dut%0d rst game_over", k), int'(go[k]), 0);
      check($sformatf("dut%0d rst win", k), int'(win[k]), 0);
    end
  endtask

  task automatic doStep(input logic [3:0] d, input bit g, input bit extra);
    bit acc [NDUT];
    int pend;
    @(negedge clk);
    dir = d; grow = g;
    for (int k = 0; k < NDUT; k++) begin
      if ($onehot(d) && d != opp(mHd[k])) mHd[k] = d;
      if (g) mGp[k] = 1'b1;
    end
    @(negedge clk);
    dir = 4'b0000; grow = 1'b0; tick = 1'b1;
    for (int k = 0; k < NDUT; k++) acc[k] = predict(k, cyc + 1);
    @(negedge clk);
    tick = 1'b0;
    for (int k = 0; k < NDUT; k++)
      check($sformatf("dut%0d busy_after_tick", k), int'(busy[k]), int'(acc[k]));
    if (extra) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    repeat (4) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      pend = 0;
      for (int i = 0; i < sbQ.size(); i++) if (sbQ[i].k == k) pend++;
      check($sformatf("dut%0d missing_event", k), pend, 0);
      check($sformatf("dut%0d idle head_x", k), int'(hx[k]), mX[k]);
      check($sformatf("dut%0d idle head_y", k), int'(hy[k]), mY[k]);
      check($sformatf("dut%0d idle length", k), getLen(k), mLen[k]);
      check($sformatf("dut%0d idle game_over", k), int'(go[k]), int'(mGo[k]));
    end
  endtask

  task automatic queryCell(input int x, input int y);
    bit inR;
    @(negedge clk);
    qx = 6'(x); qy = 6'(y);
    @(negedge clk);
    inR = (x < GW) && (y < GH);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("dut%0d q_occ(%0d,%0d)", k, x, y), int'(qocc[k]), int'(inR && inBody(k, x, y)));
      check($sformatf("dut%0d q_head(%0d,%0d)", k, x, y), int'(qhead[k]),
            int'(inR && x == mX[k] && y == mY[k]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] d;
    int r;
    modelReset();

    // Straight run right, then reversal and non-one-hot requests, plus a busy tick.
    applyReset(1'b0);
    doStep(4'b1000, 1'b0, 1'b0);
    doStep(4'b0000, 1'b0, 1'b0);
    doStep(4'b0000, 1'b0, 1'b0);
    doStep(4'b0010, 1'b0, 1'b0);
    doStep(4'b0011, 1'b0, 1'b1);
    queryCell(mX[0], mY[0]);
    queryCell(mX[0] - 1, mY[0]);

    // Grow to length 4, then circle so the head lands on the vacating tail.
    for (int pass = 0; pass < 2; pass++) begin
      applyReset(1'b0);
      doStep(4'b1000, 1'b1, 1'b0);
      queryCell(16, 16);
      queryCell(17, 16);
      doStep(4'b0000, 1'b1, 1'b0);
      doStep(4'b0000, 1'b1, 1'b0);
      doStep(4'b0100, 1'b0, 1'b0);
      doStep(4'b0010, 1'b0, 1'b0);
      doStep(4'b0001, pass == 1, 1'b0);
      queryCell(18, 16);
      queryCell(19, 16);
      doStep(4'b0000, 1'b0, 1'b0);
    end

    // Right edge: wall for the non-wrapping engines, wrap to column 0 otherwise.
    applyReset(1'b0);
    doStep(4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 47; i++) doStep(4'b0000, 1'b0, 1'b0);
    queryCell(0, 16);
    queryCell(63, 16);

    // Top edge.
    applyReset(1'b0);
    doStep(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) doStep(4'b0000, 1'b0, 1'b0);
    queryCell(16, 47);

    // Reset landing in the middle of a move.
    applyReset(1'b1);
    doStep(4'b0000, 1'b0, 1'b0);
    queryCell(16, 16);

    // Random play.
    for (int ep = 0; ep < 10; ep++) begin
      applyReset(1'b0);
      for (int s = 0; s < 40; s++) begin
        r = int'($urandom_range(0, 9));
        if (r < 3)       d = 4'(1 << $urandom_range(0, 3));
        else if (r == 3) d = 4'($urandom_range(0, 15));
        else             d = 4'b0000;
        doStep(d, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
        queryCell(mX[0], mY[0]);
        if (mLen[0] > 1) queryCell(bx[0][mLen[0]-1], by[0][mLen[0]-1]);
        queryCell(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      end
    end

    repeat (8) @(negedge clk);
    check("leftover_expectations", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
